vector_mem_sequencer: RTL
=========================

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameter N, default 20, lane data/address width in bits.
REQ-002 Parameter LANES, default 8, lanes per vector; lane index width is clog2(LANES).
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST  in  1  asynchronous reset, active-low.
REQ-005 MemWriteM  in  1  vector store present in Memory stage.
REQ-006 MemtoRegM  in  1  vector load present in Memory stage.
REQ-007 ALUResultM  in  [LANES-1:0][N-1:0]  per-lane addresses.
REQ-008 writeDataM  in  [LANES-1:0][N-1:0]  per-lane store data.
REQ-009 mem_req  out  1  scalar memory request valid.
REQ-010 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-011 mem_addr  out  N  scalar address.
REQ-012 mem_wdata  out  N  scalar write data.
REQ-013 mem_ack  in  1  memory accepted request; read data valid the same cycle.
REQ-014 mem_rdata  in  N  scalar read data.
REQ-015 RDM  out  [LANES-1:0][N-1:0]  assembled load vector to the writeback buffer.
REQ-016 StallM  out  1  freezes Fetch through Memory stage enables while 1.
REQ-017 DoneM  out  1  one-cycle pulse when the vector access completes.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-019 In IDLE with MemWriteM|MemtoRegM=1: StallM=1 combinationally; capture addresses, store data and op type; set lane=0; go to ACCESS.
REQ-020 If MemWriteM and MemtoRegM are both 1, the store SHALL take precedence.
REQ-021 In ACCESS: mem_req=1, mem_we=captured op, mem_addr=addr[lane], mem_wdata=data[lane] (0 for loads); StallM=1.
REQ-022 The request SHALL hold stable until mem_ack=1; lane advances only on ack.
REQ-023 On ack during a load, RDM[lane] SHALL capture mem_rdata; stores SHALL leave RDM unchanged.
REQ-024 On ack at lane=LANES-1: go to DONE; the lane counter SHALL NOT wrap to 0 inside ACCESS.
REQ-025 DONE SHALL last exactly one cycle with StallM=0, mem_req=0 and DoneM=1, then go to IDLE.
REQ-026 In DONE, pipeline inputs SHALL be ignored, so the completed instruction is not re-issued.
REQ-027 mem_ack while mem_req=0 SHALL be ignored.
REQ-028 With a zero-wait memory, a vector op SHALL stall for LANES+1 cycles; DONE follows on cycle LANES+1.
REQ-029 A back-to-back memory op SHALL be accepted in the IDLE cycle after DONE.
REQ-030 RDM SHALL hold its last loaded value until lanes are overwritten by a subsequent load.

Reset
REQ-031 When RST=0: state=IDLE, lane=0, RDM=0, captured registers=0, mem_req=0, mem_we=0, DoneM=0.
REQ-032 StallM SHALL be 0 during reset regardless of inputs.
REQ-033 Reset mid-ACCESS SHALL drop mem_req immediately (asynchronously) and discard partial results.

Structure
REQ-034 A shared package vector_pkg SHALL hold N, LANES, the lane-index width and the state enum (IDLE/ACCESS/DONE).
REQ-035 One sub-module, lane_counter, SHALL provide clear, increment-on-ack and last-lane flag; all other logic is in the top module.

Verification
REQ-036 Load, ack every cycle, addresses 0..7, rdata=addr+100 -> RDM={107..100}, StallM high 9 cycles, DoneM on cycle 9.
REQ-037 Store, ack delayed 2 cycles on lane 3 -> mem_addr/mem_wdata stable while waiting, 8 writes total, RDM unchanged, stall lasts 11 cycles.
REQ-038 Load in DONE immediately followed by a store -> no lane re-issued; store begins the cycle after DONE.
REQ-039 MemWriteM=MemtoRegM=1 -> mem_we=1 for all lanes, RDM unchanged.
REQ-040 RST=0 during lane 4 of a load -> mem_req=0 and StallM=0 immediately, RDM=0; a new load after release completes all 8 lanes.
REQ-041 Spurious mem_ack while in IDLE with no op -> no state change, RDM unchanged.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared sizing constants and FSM state type for the vector memory sequencer.
package vector_pkg;
  localparam int N      = 20;
  localparam int LANES  = 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/lane_counter.sv
// Lane index for the serialized vector access; saturates at the last lane.
module lane_counter #(
  parameter int LANES = vector_pkg::LANES,
  parameter int W     = vector_pkg::LANE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] lane,
  output logic         last
);
  localparam logic [W-1:0] LAST_IDX = W'(LANES - 1);

  assign last = (lane == LAST_IDX);

  // Holding at the last lane keeps the final address on the bus until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              lane <= '0;
    else if (clear)          lane <= '0;
    else if (inc && !last)   lane <= lane + W'(1);
  end
endmodule

// File: rtl/vector_mem_sequencer.sv
// Serializes a vector load/store into one scalar memory access per lane,
// stalling the pipeline until every lane has been acknowledged.
module vector_mem_sequencer #(
  parameter int N     = vector_pkg::N,
  parameter int LANES = vector_pkg::LANES
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MemWriteM,
  input  logic                    MemtoRegM,
  input  logic [LANES-1:0][N-1:0] ALUResultM,
  input  logic [LANES-1:0][N-1:0] writeDataM,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [N-1:0]            mem_addr,
  output logic [N-1:0]            mem_wdata,
  input  logic                    mem_ack,
  input  logic [N-1:0]            mem_rdata,
  output logic [LANES-1:0][N-1:0] RDM,
  output logic                    StallM,
  output logic                    DoneM
);
  import vector_pkg::*;

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                  state, state_nxt;
  logic [LANES-1:0][N-1:0] addr_q, data_q;
  logic                    we_q;
  logic [LIDX_W-1:0]       lane;
  logic                    last;
  logic                    start, in_access, ack_acc;

  // DONE does not look at the pipeline inputs, so the finished op is not re-issued.
  assign start     = (state == IDLE) && (MemWriteM || MemtoRegM);
  assign in_access = (state == ACCESS);
  assign ack_acc   = in_access && mem_ack;

  lane_counter #(
    .LANES (LANES),
    .W     (LIDX_W)
  ) u_lane (
    .clk   (CLK),
    .rst_n (RST),
    .clear (start),
    .inc   (ack_acc),
    .lane  (lane),
    .last  (last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (mem_ack && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Store wins when both op flags are raised together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      RDM    <= '0;
    end else begin
      if (start) begin
        addr_q <= ALUResultM;
        data_q <= writeDataM;
        we_q   <= MemWriteM;
      end
      if (ack_acc && !we_q) RDM[lane] <= mem_rdata;
    end
  end

  // Outputs are gated by reset so an in-flight request drops without waiting for an edge.
  assign mem_req   = RST && in_access;
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = in_access ? addr_q[lane] : '0;
  assign mem_wdata = (in_access && we_q) ? data_q[lane] : '0;
  assign StallM    = RST && (start || in_access);
  assign DoneM     = RST && (state == DONE);
endmodule
